alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares one combinational `alu` instance (32-bit A/B, 3-bit ALUOp, output C) between NREQ requesters.
- Requesters use a valid/ready handshake. A round-robin grant picks one requester, the block registers its operands, runs them through the ALU, and returns a registered result tagged with the requester ID.
- Sits between the ALU and the multi-source control logic of the P-series datapath.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, requester ID width; must equal clog2(NREQ).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  request i presents an operation.
- req_ready  out  NREQ  one-hot grant; request i accepted this cycle.
- req_a  in  NREQ*32  operand A of request i at bits [32i+31:32i].
- req_b  in  NREQ*32  operand B of request i, same packing.
- req_op  in  NREQ*3  ALUOp of request i at bits [3i+2:3i].
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer accepts the result.
- resp_c  out  32  ALU result.
- resp_id  out  IDW  index of the requester that owns resp_c.
- resp_err  out  1  op code was 6 or 7 (undefined).
- busy  out  1  high whenever the state is not S_IDLE.

Behaviour:
- Clock and reset: one clock. reset is synchronous and active-high.
- Reset values:
  - state=S_IDLE; req_ready=0; resp_valid=0; resp_c=0; resp_id=0; resp_err=0; busy=0.
  - Round-robin pointer last=NREQ-1, so requester 0 has top priority first.
- States: S_IDLE, S_EXEC, S_DONE.
- S_IDLE:
  - req_ready is combinational. Among set req_valid bits, grant the first index scanning last+1, last+2, ... modulo NREQ.
  - On a grant at edge T: capture a_r, b_r, op_r and id_r; last <= granted index; go to S_EXEC.
  - No valid bit set: stay in S_IDLE, req_ready=0.
- S_EXEC:
  - ALU inputs are driven only from a_r/b_r/op_r, never from the live request buses.
  - At the next edge: resp_c <= C; resp_id <= id_r; resp_err <= (op_r>5); resp_valid <= 1; go to S_DONE.
- S_DONE:
  - Hold resp_* stable while resp_ready=0.
  - On resp_valid & resp_ready: resp_valid <= 0, go to S_IDLE. resp_c/resp_id keep their old values.
- Timing:
  - Latency: grant at edge T, resp_valid visible after edge T+1.
  - Minimum issue interval is 3 cycles. req_ready is 0 outside S_IDLE.
- Requester rules: a requester must hold its a/b/op stable while its req_valid=1 and not granted. Dropping req_valid before a grant is legal and not an error.
- Simultaneous requests: exactly one req_ready bit per grant. Fairness: a continuously requesting master waits at most NREQ-1 grants.
- Undefined op (6/7): still executed. The ALU returns 0, so resp_c=0 and resp_err=1. The pointer advances normally.
- Reset in any state: the in-flight operation is discarded with no response, and all outputs return to reset values at that edge.
- Arithmetic:
  - 32-bit modulo add/sub, no carry or overflow output.
  - Shifts use B[4:0].
  - Op codes: 0 add, 1 sub, 2 and, 3 or, 4 srl (A>>B), 5 sra (A>>>B).

Decomposition:
- Package alu_pkg:
  - ALU op constants OP_ADD=0, OP_SUB=1, OP_AND=2, OP_OR=3, OP_SRL=4, OP_SRA=5.
  - Parameter OP_MAX=5.
  - 2-bit state encoding S_IDLE=0, S_EXEC=1, S_DONE=2.
- Sub-module: one instance of the existing `alu` (ports A, B, ALUOp, C), driven from the operand registers.
- The round-robin pick is a combinational function inside alu_arbiter; it is not a separate module.

Test Plan:
- Single request, ALU results: req 0, A=7, B=16, op=0 → resp_c=23, id=0, err=0, resp_valid two edges after the grant. The same operands with op=1 → 0xFFFFFFF7, op=2 → 0, op=3 → 23.
- Shifts: A=0x80000000, B=4. op=4 → 0x08000000; op=5 → 0xF8000000.
- Fairness: all 4 req_valid held high, each completing with resp_ready=1 → grant order 0,1,2,3,0; the resp_id sequence matches.
- Backpressure: resp_ready=0 for 5 cycles after resp_valid → resp_c/resp_id stable, req_ready=0 throughout. resp_ready=1 → returns to S_IDLE next edge.
- Undefined op: req 2, op=7, A=5, B=3 → resp_c=0, resp_err=1, id=2. A following request from req 3 → grant goes to 3.
- Reset mid-operation: reset asserted in S_EXEC → no resp_valid, busy=0 next cycle. A simultaneous req 1 and req 3 after reset → req 1 granted, because the pointer was reset to 3 and the scan starts at 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its round-robin arbiter front end.
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_SRL = 3'd4;
    localparam logic [2:0] OP_SRA = 3'd5;

    localparam logic [2:0] OP_MAX = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU; undefined op codes produce zero.
module alu
    import alu_pkg::*;
(
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [2:0]  ALUOp,
    output logic [31:0] C
);

    always_comb begin
        C = '0;
        case (ALUOp)
            OP_ADD:  C = A + B;
            OP_SUB:  C = A - B;
            OP_AND:  C = A & B;
            OP_OR:   C = A | B;
            OP_SRL:  C = A >> B[4:0];
            OP_SRA:  C = $unsigned($signed(A) >>> B[4:0]);
            default: C = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU among NREQ valid/ready requesters;
// one operation in flight, result returned with the owner's ID.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*32-1:0]   req_a,
    input  logic [NREQ*32-1:0]   req_b,
    input  logic [NREQ*3-1:0]    req_op,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [31:0]          resp_c,
    output logic [IDW-1:0]       resp_id,
    output logic                 resp_err,
    output logic                 busy
);

    state_e         state_q, state_d;
    logic [IDW-1:0] last_q, last_d;
    logic [31:0]    a_q, a_d, b_q, b_d;
    logic [2:0]     op_q, op_d;
    logic [IDW-1:0] id_q, id_d;
    logic           resp_valid_q, resp_valid_d;
    logic [31:0]    resp_c_q, resp_c_d;
    logic [IDW-1:0] resp_id_q, resp_id_d;
    logic           resp_err_q, resp_err_d;

    logic [31:0]    alu_c;
    logic           grant_found;
    logic [IDW-1:0] grant_idx;

    // Returns {found, index}: first valid bit scanning last+1, last+2, ... mod NREQ.
    function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] valid,
                                             input logic [IDW-1:0]  last);
        logic [IDW:0]   pick;
        logic [IDW-1:0] idx_w;
        int             idx;
        pick = '0;
        for (int i = 1; i <= NREQ; i++) begin
            idx   = (int'(last) + i) % NREQ;
            idx_w = idx[IDW-1:0];
            if (!pick[IDW] && valid[idx_w]) begin
                pick = {1'b1, idx_w};
            end
        end
        return pick;
    endfunction

    always_comb begin
        {grant_found, grant_idx} = rr_pick(req_valid, last_q);
    end

    alu u_alu (
        .A     (a_q),
        .B     (b_q),
        .ALUOp (op_q),
        .C     (alu_c)
    );

    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        a_d          = a_q;
        b_d          = b_q;
        op_d         = op_q;
        id_d         = id_q;
        resp_valid_d = resp_valid_q;
        resp_c_d     = resp_c_q;
        resp_id_d    = resp_id_q;
        resp_err_d   = resp_err_q;
        req_ready    = '0;

        case (state_q)
            S_IDLE: begin
                if (grant_found && !reset) begin
                    req_ready[grant_idx] = 1'b1;
                    a_d     = req_a[32*grant_idx +: 32];
                    b_d     = req_b[32*grant_idx +: 32];
                    op_d    = req_op[3*grant_idx +: 3];
                    id_d    = grant_idx;
                    last_d  = grant_idx;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                resp_c_d     = alu_c;
                resp_id_d    = id_q;
                resp_err_d   = (op_q > OP_MAX);
                resp_valid_d = 1'b1;
                state_d      = S_DONE;
            end
            S_DONE: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            last_q       <= IDW'(NREQ - 1);
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= '0;
            id_q         <= '0;
            resp_valid_q <= 1'b0;
            resp_c_q     <= '0;
            resp_id_q    <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            a_q          <= a_d;
            b_q          <= b_d;
            op_q         <= op_d;
            id_q         <= id_d;
            resp_valid_q <= resp_valid_d;
            resp_c_q     <= resp_c_d;
            resp_id_q    <= resp_id_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_c     = resp_c_q;
    assign resp_id    = resp_id_q;
    assign resp_err   = resp_err_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed table-driven bench for alu_arbiter plus fairness, backpressure and reset sequences.
module tb_alu_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic                clk = 1'b0;
    logic                reset;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*32-1:0]  req_a;
    logic [NREQ*32-1:0]  req_b;
    logic [NREQ*3-1:0]   req_op;
    logic                resp_valid;
    logic                resp_ready;
    logic [31:0]         resp_c;
    logic [IDW-1:0]      resp_id;
    logic                resp_err;
    logic                busy;

    int total = 0;
    int bad   = 0;

    alu_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_c     (resp_c),
        .resp_id    (resp_id),
        .resp_err   (resp_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          r;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic [31:0] c;
        logic        err;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic set_req(input int r, input logic [31:0] a, input logic [31:0] b,
                           input logic [2:0] op);
        req_a[32*r +: 32] = a;
        req_b[32*r +: 32] = b;
        req_op[3*r +: 3]  = op;
    endtask

    task automatic run_op(input vec_t v);
        set_req(v.r, v.a, v.b, v.op);
        req_valid = NREQ'(1) << v.r;
        #1;
        check("grant_onehot", 32'(req_ready), 32'(NREQ'(1) << v.r));
        tick();
        req_valid = '0;
        check("exec_busy", 32'(busy), 32'd1);
        check("exec_no_valid", 32'(resp_valid), 32'd0);
        check("exec_ready_low", 32'(req_ready), 32'd0);
        tick();
        check("resp_valid", 32'(resp_valid), 32'd1);
        check("resp_c", resp_c, v.c);
        check("resp_id", 32'(resp_id), 32'(v.r));
        check("resp_err", 32'(resp_err), 32'(v.err));
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check("idle_valid", 32'(resp_valid), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        int n;
        int exp_id;

        vecs[0] = '{0, 32'd7, 32'd16, 3'd0, 32'd23, 1'b0};
        vecs[1] = '{0, 32'd7, 32'd16, 3'd1, 32'hFFFF_FFF7, 1'b0};
        vecs[2] = '{0, 32'd7, 32'd16, 3'd2, 32'd0, 1'b0};
        vecs[3] = '{0, 32'd7, 32'd16, 3'd3, 32'd23, 1'b0};
        vecs[4] = '{1, 32'h8000_0000, 32'd4, 3'd4, 32'h0800_0000, 1'b0};
        vecs[5] = '{1, 32'h8000_0000, 32'd4, 3'd5, 32'hF800_0000, 1'b0};
        vecs[6] = '{2, 32'd5, 32'd3, 3'd7, 32'd0, 1'b1};
        vecs[7] = '{3, 32'd100, 32'd1, 3'd1, 32'd99, 1'b0};
        vecs[8] = '{3, 32'hF0F0_0000, 32'h0000_0024, 3'd4, 32'h0F0F_0000, 1'b0};
        vecs[9] = '{2, 32'hFFFF_FFFF, 32'd1, 3'd6, 32'd0, 1'b1};

        reset      = 1'b1;
        req_valid  = '1;
        req_a      = '0;
        req_b      = '0;
        req_op     = '0;
        resp_ready = 1'b0;
        tick();
        tick();
        check("rst_ready_held", 32'(req_ready), 32'd0);
        req_valid = '0;
        reset     = 1'b0;
        #1;
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_valid", 32'(resp_valid), 32'd0);
        check("rst_c", resp_c, 32'd0);
        check("rst_id", 32'(resp_id), 32'd0);
        check("rst_err", 32'(resp_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i]);
        end

        // Fairness: all requesters held high, order 0,1,2,3,0 from a fresh pointer.
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            set_req(i, 32'(i * 10), 32'd1, 3'd0);
        end
        req_valid  = '1;
        resp_ready = 1'b1;
        #1;
        for (int g = 0; g < 5; g++) begin
            exp_id = g % NREQ;
            n = 0;
            while (req_ready == '0 && n < 10) begin
                tick();
                n++;
            end
            check("fair_grant", 32'(req_ready), 32'(NREQ'(1) << exp_id));
            tick();
            n = 0;
            while (!resp_valid && n < 10) begin
                tick();
                n++;
            end
            check("fair_resp_valid", 32'(resp_valid), 32'd1);
            check("fair_resp_id", 32'(resp_id), 32'(exp_id));
            check("fair_resp_c", resp_c, 32'(exp_id * 10 + 1));
            tick();
        end
        req_valid  = '0;
        resp_ready = 1'b0;

        // Backpressure: result held while resp_ready low, competing request not granted.
        do_reset();
        set_req(1, 32'd10, 32'd20, 3'd0);
        set_req(0, 32'd1, 32'd1, 3'd1);
        req_valid = 4'b0010;
        tick();
        req_valid = 4'b0001;
        tick();
        for (int k = 0; k < 5; k++) begin
            check("bp_valid", 32'(resp_valid), 32'd1);
            check("bp_c", resp_c, 32'd30);
            check("bp_id", 32'(resp_id), 32'd1);
            check("bp_ready_low", 32'(req_ready), 32'd0);
            tick();
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check("bp_release_valid", 32'(resp_valid), 32'd0);
        check("bp_release_busy", 32'(busy), 32'd0);
        check("bp_next_grant", 32'(req_ready), 32'b0001);
        check("bp_keep_c", resp_c, 32'd30);
        req_valid = '0;
        tick();
        tick();
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;

        // Reset during S_EXEC discards the op and restores the pointer.
        set_req(2, 32'd1, 32'd2, 3'd0);
        req_valid = 4'b0100;
        tick();
        req_valid = '0;
        check("mid_busy_before", 32'(busy), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_busy", 32'(busy), 32'd0);
        check("mid_valid", 32'(resp_valid), 32'd0);
        tick();
        check("mid_valid_later", 32'(resp_valid), 32'd0);
        req_valid = 4'b1010;
        #1;
        check("mid_rr_grant", 32'(req_ready), 32'b0010);
        req_valid = '0;
        do_reset();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
